// File: rtl/moving_sum_ctrl_pkg.sv
// Shared types and helpers for the moving-sum run-time controller.
package moving_sum_ctrl_pkg;

  // Controller phases: normal streaming, draining in-flight samples, and
  // the single cycle in which the datapath is cleared and reloaded.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Width of the window-length field for a given maximum length.
  function automatic int calc_lw(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of the complex sum output (I and Q, each grown by LW bits).
  function automatic int calc_ow(input int width, input int lw);
    return 2 * (width + lw);
  endfunction

  // A zero-length window is meaningless, and lengths beyond MAX_LEN do not
  // fit the datapath delay line, so both are pulled into range.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/moving_sum_ctrl_inflight.sv
// Saturating up/down count of samples inside the moving-sum datapath.
// full stalls the input; empty tells the controller the pipe has drained.
module moving_sum_ctrl_inflight #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [W-1:0] count;

  // Count accepted inputs minus emitted outputs, never wrapping either way.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - W'(1);
    end
  end

  assign full  = (count == '1);
  assign empty = (count == '0);

endmodule

// File: rtl/moving_sum_ctrl.sv
// Run-time controller for moving_sum_complex: owns the datapath len/clear,
// applies new window lengths at a packet boundary after draining, and passes
// both sample streams through with zero latency.
// Optional feature: define MOVING_SUM_CTRL_WARMUP_DROP_EN to swallow the
// first ms_len-1 outputs after every datapath clear (partial-window sums).
module moving_sum_ctrl
  import moving_sum_ctrl_pkg::*;
#(
  parameter int MAX_LEN     = 1023,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_LEN = 16,
  parameter int INFLIGHT_W  = 4,
  localparam int LW = calc_lw(MAX_LEN),
  localparam int OW = calc_ow(WIDTH, LW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2*WIDTH-1:0] s_tdata,
  input  logic               s_tlast,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [LW-1:0]      ms_len,
  output logic               ms_clear,
  output logic [2*WIDTH-1:0] ms_i_tdata,
  output logic               ms_i_tlast,
  output logic               ms_i_tvalid,
  input  logic               ms_i_tready,
  input  logic [OW-1:0]      ms_o_tdata,
  input  logic               ms_o_tlast,
  input  logic               ms_o_tvalid,
  output logic               ms_o_tready,
  output logic [OW-1:0]      m_tdata,
  output logic               m_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               busy
);

  state_t        state;
  logic [LW-1:0] pend_len;
  logic          in_pkt;
  logic          gate;
  logic          drop;
  logic          in_hs;
  logic          inflight_full;
  logic          inflight_empty;

  // Input may flow in RUN, or in DRAIN until the open packet closes, and
  // only while the datapath still has room for another sample.
  always_comb begin
    // NOTE: default first so no path leaves gate unassigned (no latch).
    gate = 1'b0;
    if (!reset && !inflight_full) begin
      case (state)
        ST_RUN:   gate = 1'b1;
        ST_DRAIN: gate = in_pkt;
        default:  gate = 1'b0;
      endcase
    end
  end

  assign ms_i_tdata  = s_tdata;
  assign ms_i_tlast  = s_tlast;
  assign ms_i_tvalid = s_tvalid & gate;
  assign s_tready    = ms_i_tready & gate;
  assign in_hs       = s_tvalid & s_tready;

  assign cfg_ready = ~reset & (state == ST_RUN);
  assign ms_clear  = ~reset & (clear | (state == ST_CLEAR));
  assign busy      = (state != ST_RUN);

  assign m_tdata     = ms_o_tdata;
  assign m_tlast     = ms_o_tlast;
  assign m_tvalid    = ~reset & ms_o_tvalid & ~drop;
  assign ms_o_tready = ~reset & (m_tready | drop);

  moving_sum_ctrl_inflight #(
    .W (INFLIGHT_W)
  ) u_inflight (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (in_hs),
    .dec   (ms_o_tvalid & ms_o_tready),
    .full  (inflight_full),
    .empty (inflight_empty)
  );

  // Length-change sequencer plus packet tracking; soft clear overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      ms_len   <= LW'(DEFAULT_LEN);
      pend_len <= LW'(DEFAULT_LEN);
      in_pkt   <= 1'b0;
    end else if (clear) begin
      state  <= ST_RUN;
      in_pkt <= 1'b0;
    end else begin
      if (in_hs) in_pkt <= ~s_tlast;
      case (state)
        ST_RUN: begin
          if (cfg_valid) begin
            pend_len <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!in_pkt && inflight_empty) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          ms_len <= pend_len;
          state  <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef MOVING_SUM_CTRL_WARMUP_DROP_EN
  logic [LW-1:0] warm_cnt;
  logic          warm_done;
  logic          out_hs;

  assign out_hs    = ms_o_tvalid & ms_o_tready;
  assign warm_done = (warm_cnt >= ms_len - LW'(1));
  // Packet ends are always delivered so downstream framing survives.
  assign drop      = ~warm_done & ~ms_o_tlast;

  // Count outputs since the last datapath clear, stopping once warm. After
  // reset the window is treated as already warm.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= LW'(DEFAULT_LEN - 1);
    end else if (ms_clear) begin
      warm_cnt <= '0;
    end else if (out_hs && !warm_done) begin
      warm_cnt <= warm_cnt + LW'(1);
    end
  end
`else
  assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_moving_sum_ctrl.sv
// Self-checking bench for moving_sum_ctrl: a datapath stand-in (queue with
// random output valid) plus a spec-level model compared every cycle.
module tb_moving_sum_ctrl;

  localparam int MAX_LEN     = 1000;
  localparam int WIDTH       = 16;
  localparam int DEFAULT_LEN = 16;
  localparam int INFLIGHT_W  = 4;
  localparam int LW          = 10;  // clog2(1001)
  localparam int OW          = 52;  // 2*(16+10)
  localparam int SAT         = 15;
  localparam int M_RUN = 0, M_DRAIN = 1, M_CLEAR = 2;
`ifdef MOVING_SUM_CTRL_WARMUP_DROP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, clear, cfg_valid, cfg_ready;
  logic [LW-1:0]      cfg_len, ms_len;
  logic [2*WIDTH-1:0] s_tdata, ms_i_tdata;
  logic               s_tlast, s_tvalid, s_tready;
  logic               ms_clear, ms_i_tlast, ms_i_tvalid, ms_i_tready;
  logic [OW-1:0]      ms_o_tdata, m_tdata;
  logic               ms_o_tlast, ms_o_tvalid, ms_o_tready;
  logic               m_tlast, m_tvalid, m_tready, busy;

  always #5 clk = ~clk;

  moving_sum_ctrl #(
    .MAX_LEN(MAX_LEN), .WIDTH(WIDTH), .DEFAULT_LEN(DEFAULT_LEN), .INFLIGHT_W(INFLIGHT_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cfg_len(cfg_len), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .ms_len(ms_len), .ms_clear(ms_clear),
    .ms_i_tdata(ms_i_tdata), .ms_i_tlast(ms_i_tlast), .ms_i_tvalid(ms_i_tvalid),
    .ms_i_tready(ms_i_tready),
    .ms_o_tdata(ms_o_tdata), .ms_o_tlast(ms_o_tlast), .ms_o_tvalid(ms_o_tvalid),
    .ms_o_tready(ms_o_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stimulus requests, applied at the next falling edge.
  logic          d_reset = 1'b1, d_clear = 1'b0, d_cfg_valid = 1'b0;
  logic [LW-1:0] d_cfg_len = '0;
  logic          d_s_tvalid = 1'b0, d_s_tlast = 1'b0, d_ms_i_tready = 1'b1;
  logic [31:0]   d_s_tdata = '0;
  logic          d_m_tready = 1'b1, d_dp_offer = 1'b1;

  // Datapath stand-in: accepted samples emerge later, tagged with a sequence.
  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t dp_q[$];
  int    out_seq = 0;
  int    n_del   = 0;
  bit    arm_first = 1'b0;
  int    first_seq = -1;

  // Spec-level model state.
  bit m_valid = 1'b0;
  int m_st = M_RUN, m_len = DEFAULT_LEN, m_pend = DEFAULT_LEN;
  int m_inflight = 0, m_warm = DEFAULT_LEN - 1;
  bit m_in_pkt = 1'b0;

  // Observations of the most recent cycle for directed checks.
  logic          o_cfg_ready, o_s_tready, o_ms_clear, o_busy, o_s_hs;
  logic [LW-1:0] o_ms_len;

  function automatic int model_clamp(input int req);
    if (req == 0) return 1;
    if (req > MAX_LEN) return MAX_LEN;
    return req;
  endfunction

  task automatic step();
    bit e_gate, e_s_tready, e_msi_v, e_drop, e_mso_r, e_m_v, e_cfg_r, e_clr, e_busy;
    bit e_in, e_out, act_in, act_out, act_m;
    int nxt_st;
    @(negedge clk);
    reset = d_reset; clear = d_clear; cfg_valid = d_cfg_valid; cfg_len = d_cfg_len;
    s_tvalid = d_s_tvalid; s_tlast = d_s_tlast; s_tdata = d_s_tdata;
    ms_i_tready = d_ms_i_tready; m_tready = d_m_tready;
    if (dp_q.size() > 0) begin
      ms_o_tvalid = d_dp_offer;
      ms_o_tdata  = {out_seq[19:0], dp_q[0].data};
      ms_o_tlast  = dp_q[0].last;
    end else begin
      ms_o_tvalid = 1'b0; ms_o_tdata = '0; ms_o_tlast = 1'b0;
    end
    #1;
    e_gate     = !d_reset && (m_st == M_RUN || (m_st == M_DRAIN && m_in_pkt)) && (m_inflight < SAT);
    e_s_tready = d_ms_i_tready && e_gate;
    e_msi_v    = d_s_tvalid && e_gate;
    e_drop     = WARM && (m_warm < m_len - 1) && !ms_o_tlast;
    e_mso_r    = !d_reset && (d_m_tready || e_drop);
    e_m_v      = !d_reset && ms_o_tvalid && !e_drop;
    e_cfg_r    = !d_reset && (m_st == M_RUN);
    e_clr      = !d_reset && (d_clear || m_st == M_CLEAR);
    e_busy     = (m_st != M_RUN);
    if (m_valid) begin
      check_bit("cfg_ready", cfg_ready, e_cfg_r);
      check_bit("s_tready", s_tready, e_s_tready);
      check_bit("ms_i_tvalid", ms_i_tvalid, e_msi_v);
      check_bit("ms_clear", ms_clear, e_clr);
      check_bit("busy", busy, e_busy);
      check_val("ms_len", 64'(ms_len), 64'(m_len));
      check_bit("m_tvalid", m_tvalid, e_m_v);
      check_bit("ms_o_tready", ms_o_tready, e_mso_r);
      check_val("ms_i_tdata", 64'(ms_i_tdata), 64'(d_s_tdata));
      check_bit("ms_i_tlast", ms_i_tlast, d_s_tlast);
      if (e_m_v) begin
        check_val("m_tdata", 64'(m_tdata), 64'(ms_o_tdata));
        check_bit("m_tlast", m_tlast, ms_o_tlast);
      end
    end
    o_cfg_ready = cfg_ready; o_s_tready = s_tready; o_ms_clear = ms_clear;
    o_busy = busy; o_ms_len = ms_len; o_s_hs = s_tvalid && s_tready;
    // Environment reacts to what the DUT actually did.
    act_in  = ms_i_tvalid && ms_i_tready;
    act_out = ms_o_tvalid && ms_o_tready;
    act_m   = m_tvalid && m_tready;
    if (act_m) begin
      n_del++;
      if (arm_first) begin first_seq = int'(m_tdata[51:32]); arm_first = 1'b0; end
    end
    if (act_out) begin void'(dp_q.pop_front()); out_seq++; end
    if (act_in) dp_q.push_back('{data: ms_i_tdata, last: ms_i_tlast});
    if (ms_clear === 1'b1 || d_reset) dp_q.delete();
    // Model advances on the handshakes the spec says must happen.
    e_in  = d_s_tvalid && e_s_tready;
    e_out = ms_o_tvalid && e_mso_r;
    if (d_reset) begin
      m_st = M_RUN; m_len = DEFAULT_LEN; m_pend = DEFAULT_LEN; m_in_pkt = 1'b0;
      m_inflight = 0; m_warm = DEFAULT_LEN - 1; m_valid = 1'b1;
    end else if (d_clear) begin
      m_st = M_RUN; m_in_pkt = 1'b0; m_inflight = 0; m_warm = 0;
    end else begin
      nxt_st = m_st;
      if (e_out && m_warm < m_len - 1) m_warm++;
      if (m_st == M_RUN) begin
        if (d_cfg_valid) begin m_pend = model_clamp(int'(d_cfg_len)); nxt_st = M_DRAIN; end
      end else if (m_st == M_DRAIN) begin
        if (!m_in_pkt && m_inflight == 0) nxt_st = M_CLEAR;
      end else begin
        m_len = m_pend; m_warm = 0; nxt_st = M_RUN;
      end
      m_inflight += int'(e_in) - int'(e_out);
      if (e_in) m_in_pkt = !d_s_tlast;
      m_st = nxt_st;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    d_reset = 1'b0; d_clear = 1'b0; d_cfg_valid = 1'b0; d_s_tvalid = 1'b0; d_s_tlast = 1'b0;
    d_m_tready = 1'b1; d_dp_offer = 1'b1; d_ms_i_tready = 1'b1;
  endtask

  task automatic drain_idle();
    int c;
    idle_inputs();
    for (c = 0; c < 300; c++) begin
      if (m_st == M_RUN && dp_q.size() == 0) break;
      step();
    end
    if (c == 300) check_bit("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_beats(input int n, input bit end_pkt, input int bound, output int got);
    got = 0;
    for (int c = 0; c < bound && got < n; c++) begin
      d_s_tvalid = 1'b1;
      d_s_tlast  = end_pkt && (got == n - 1);
      d_s_tdata  = $urandom;
      step();
      if (o_s_hs) got++;
    end
    d_s_tvalid = 1'b0; d_s_tlast = 1'b0;
  endtask

  task automatic do_cfg(input int req, input int exp_len, input string name);
    drain_idle();
    d_cfg_valid = 1'b1; d_cfg_len = LW'(req);
    step();
    d_cfg_valid = 1'b0;
    repeat (3) step();
    check_val(name, 64'(o_ms_len), 64'(exp_len));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, base, del0, acc;
    bit seen;
    reset = 1'b1; clear = 1'b0; cfg_valid = 1'b0; cfg_len = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; ms_i_tready = 1'b1;
    ms_o_tvalid = 1'b0; ms_o_tdata = '0; ms_o_tlast = 1'b0; m_tready = 1'b1;

    // Reset: outputs held off while reset is high, even with input offered.
    d_reset = 1'b1; d_s_tvalid = 1'b1;
    repeat (3) step();
    check_bit("rst_cfg_ready", o_cfg_ready, 1'b0);
    check_bit("rst_s_tready", o_s_tready, 1'b0);
    idle_inputs();
    step();
    check_val("rst_ms_len", 64'(o_ms_len), 64'(16));
    check_bit("rst_busy", o_busy, 1'b0);

    // Stream 20 beats straight through.
    del0 = n_del;
    send_beats(20, 1'b1, 200, got);
    check_val("stream20_accepted", 64'(got), 64'(20));
    drain_idle();
    check_val("stream20_delivered", 64'(n_del - del0), 64'(20));
    check_val("stream20_len", 64'(o_ms_len), 64'(16));

    // Idle length change: DRAIN at T+1, CLEAR at T+2, new length at T+3.
    d_cfg_valid = 1'b1; d_cfg_len = LW'(8);
    step();
    check_bit("cfg8_T_ready", o_cfg_ready, 1'b1);
    d_cfg_valid = 1'b0;
    step();
    check_bit("cfg8_T1_ready", o_cfg_ready, 1'b0);
    check_bit("cfg8_T1_clear", o_ms_clear, 1'b0);
    check_bit("cfg8_T1_busy", o_busy, 1'b1);
    step();
    check_bit("cfg8_T2_clear", o_ms_clear, 1'b1);
    check_bit("cfg8_T2_ready", o_cfg_ready, 1'b0);
    step();
    check_bit("cfg8_T3_clear", o_ms_clear, 1'b0);
    check_bit("cfg8_T3_ready", o_cfg_ready, 1'b1);
    check_val("cfg8_T3_len", 64'(o_ms_len), 64'(8));

    // Change requested mid-packet: the packet finishes, then input stalls.
    d_m_tready = 1'b0;
    send_beats(3, 1'b0, 50, got);
    d_cfg_valid = 1'b1; d_cfg_len = LW'(4);
    step();
    check_bit("mid_cfg_ready", o_cfg_ready, 1'b1);
    d_cfg_valid = 1'b0;
    send_beats(5, 1'b1, 50, got);
    check_val("mid_tail_accepted", 64'(got), 64'(5));
    d_s_tvalid = 1'b1;
    repeat (3) begin
      step();
      check_bit("mid_gated", o_s_tready, 1'b0);
    end
    d_s_tvalid = 1'b0; d_m_tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      seen = o_ms_clear;
    end
    check_bit("mid_clear_seen", seen, 1'b1);
    step();
    check_val("mid_len", 64'(o_ms_len), 64'(4));

    // Saturation: the datapath holds its outputs, so only 15 beats get in.
    drain_idle();
    del0 = n_del; acc = 0;
    d_dp_offer = 1'b0; d_s_tvalid = 1'b1; d_s_tlast = 1'b0;
    repeat (30) begin
      d_s_tdata = $urandom;
      step();
      if (o_s_hs) acc++;
    end
    check_val("sat_accepted", 64'(acc), 64'(SAT));
    check_bit("sat_stalled", o_s_tready, 1'b0);
    d_dp_offer = 1'b1; d_m_tready = 1'b1;
    send_beats(1, 1'b1, 100, got);
    drain_idle();
    check_val("sat_delivered", 64'(n_del - del0), WARM ? 64'(13) : 64'(16));

    // Soft clear restarts the warm-up with ms_len=4.
    base = out_seq; del0 = n_del;
    d_clear = 1'b1;
    step();
    d_clear = 1'b0; arm_first = 1'b1;
    send_beats(4, 1'b1, 100, got);
    drain_idle();
    check_val("warm_first_seq", 64'(first_seq), WARM ? 64'(base + 3) : 64'(base));
    check_val("warm_delivered", 64'(n_del - del0), WARM ? 64'(1) : 64'(4));

    // Length clamping at both ends.
    do_cfg(0, 1, "clamp_zero");
    do_cfg(1023, MAX_LEN, "clamp_over");
    do_cfg(MAX_LEN, MAX_LEN, "clamp_exact");
    do_cfg(1, 1, "clamp_one");

    // Soft clear wins over a same-cycle config request.
    drain_idle();
    d_clear = 1'b1; d_cfg_valid = 1'b1; d_cfg_len = LW'(7);
    step();
    d_clear = 1'b0; d_cfg_valid = 1'b0;
    step();
    check_bit("clr_prio_busy", o_busy, 1'b0);
    repeat (2) step();
    check_val("clr_prio_len", 64'(o_ms_len), 64'(1));

    // Randomized traffic with occasional config, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      d_s_tvalid    = ($urandom_range(0, 9) < 7);
      d_s_tlast     = ($urandom_range(0, 3) == 0);
      d_s_tdata     = $urandom;
      d_ms_i_tready = ($urandom_range(0, 9) < 8);
      d_dp_offer    = ($urandom_range(0, 9) < 7);
      d_m_tready    = ($urandom_range(0, 9) < 6);
      d_cfg_valid   = ($urandom_range(0, 99) < 3);
      d_cfg_len     = LW'($urandom_range(0, 1023));
      d_clear       = ($urandom_range(0, 99) == 0);
      d_reset       = ($urandom_range(0, 999) < 3);
      step();
    end
    idle_inputs();
    d_clear = 1'b1;
    step();
    drain_idle();
    check_bit("final_idle", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
